imm_gen_pipe: RTL and testbench

//  Registered, handshaked immediate generator for the decode stage: takes a 32-bit instruction

---
 rtl/imm_pkg.sv | 30 +++
 rtl/imm_decode.sv | 64 ++++++
 rtl/imm_gen_pipe.sv | 128 ++++++++++++
 tb/tb_imm_gen_pipe.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared types for the immediate generator: format selects, RV opcodes and skid-buffer states.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I  = 3'b000,
    IMM_S  = 3'b001,
    IMM_B  = 3'b010,
    IMM_U  = 3'b011,
    IMM_J  = 3'b100,
    IMM_Z  = 3'b101,
    IMM_SH = 3'b110
  } imm_sel_e;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extractor: instr + format (or opcode when AUTO_SEL) -> XLEN immediate.
// Optional CSR zimm / shamt formats are enabled by defining IMM_GEN_ZICSR_EN.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int AUTO_SEL = 0
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      sel,
  output logic [XLEN-1:0] imm,
  output logic            err
);

  logic [2:0]  eff_sel;
  logic        opc_err;
  logic [31:0] imm32;
  logic        s;

  assign s = instr[31];

  always_comb begin
    eff_sel = sel;
    opc_err = 1'b0;
    if (AUTO_SEL != 0) begin
      case (instr[6:0])
        OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: eff_sel = IMM_I;
        OPC_STORE:                                  eff_sel = IMM_S;
        OPC_BRANCH:                                 eff_sel = IMM_B;
        OPC_LUI, OPC_AUIPC:                         eff_sel = IMM_U;
        OPC_JAL:                                    eff_sel = IMM_J;
        default: begin
          eff_sel = IMM_I;
          opc_err = 1'b1;
        end
      endcase
    end
  end

  // Every format is built as a 32-bit value whose bit 31 is the correct extension bit,
  // so a single sign-extension covers both XLEN=32 and the RV64 LUI case.
  always_comb begin
    imm32 = {{20{s}}, instr[31:20]};
    err   = opc_err;
    case (eff_sel)
      IMM_I: imm32 = {{20{s}}, instr[31:20]};
      IMM_S: imm32 = {{20{s}}, instr[31:25], instr[11:7]};
      IMM_B: imm32 = {{19{s}}, s, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U: imm32 = {instr[31:12], 12'b0};
      IMM_J: imm32 = {{11{s}}, s, instr[19:12], instr[20], instr[30:21], 1'b0};
`ifdef IMM_GEN_ZICSR_EN
      IMM_Z: imm32 = {27'b0, instr[19:15]};
      IMM_SH: begin
        if (XLEN == 64) imm32 = {26'b0, instr[25:20]};
        else            imm32 = {27'b0, instr[24:20]};
      end
`endif
      default: err = 1'b1;
    endcase
  end

  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a main register (M) and a one-entry skid register (K).
// Build option IMM_GEN_ZICSR_EN adds the Z and SH formats inside imm_decode.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int TAG_W    = 32,
  parameter int AUTO_SEL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  logic [XLEN-1:0] dec_imm;
  logic            dec_err;

  imm_decode #(
    .XLEN     (XLEN),
    .AUTO_SEL (AUTO_SEL)
  ) u_decode (
    .instr (in_instr),
    .sel   (in_sel),
    .imm   (dec_imm),
    .err   (dec_err)
  );

  buf_state_e      state_q, state_d;
  logic [XLEN-1:0] m_imm_q, m_imm_d, k_imm_q, k_imm_d;
  logic [TAG_W-1:0] m_tag_q, m_tag_d, k_tag_q, k_tag_d;
  logic            m_err_q, m_err_d, k_err_q, k_err_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            in_acc, out_acc;

  assign in_acc  = in_valid && in_ready_q;
  assign out_acc = out_valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    m_imm_d = m_imm_q;
    m_tag_d = m_tag_q;
    m_err_d = m_err_q;
    k_imm_d = k_imm_q;
    k_tag_d = k_tag_q;
    k_err_d = k_err_q;
    case (state_q)
      BUF_EMPTY: begin
        if (in_acc) begin
          m_imm_d = dec_imm;
          m_tag_d = in_tag;
          m_err_d = dec_err;
          state_d = BUF_ONE;
        end
      end
      BUF_ONE: begin
        // A word arriving while M drains goes straight into M.
        if (in_acc && out_acc) begin
          m_imm_d = dec_imm;
          m_tag_d = in_tag;
          m_err_d = dec_err;
        end else if (in_acc) begin
          k_imm_d = dec_imm;
          k_tag_d = in_tag;
          k_err_d = dec_err;
          state_d = BUF_FULL;
        end else if (out_acc) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_FULL: begin
        if (out_acc) begin
          m_imm_d = k_imm_q;
          m_tag_d = k_tag_q;
          m_err_d = k_err_q;
          state_d = BUF_ONE;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
    out_valid_d = (state_d != BUF_EMPTY);
    in_ready_d  = (state_d != BUF_FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= BUF_EMPTY;
      m_imm_q     <= '0;
      m_tag_q     <= '0;
      m_err_q     <= 1'b0;
      k_imm_q     <= '0;
      k_tag_q     <= '0;
      k_err_q     <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      m_imm_q     <= m_imm_d;
      m_tag_q     <= m_tag_d;
      m_err_q     <= m_err_d;
      k_imm_q     <= k_imm_d;
      k_tag_q     <= k_tag_d;
      k_err_q     <= k_err_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_imm   = m_imm_q;
  assign out_tag   = m_tag_q;
  assign out_err   = m_err_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench: XLEN=32, XLEN=64 and AUTO_SEL instances share one stimulus stream.
module tb_imm_gen_pipe;

`ifdef IMM_GEN_ZICSR_EN
  localparam bit ZICSR = 1'b1;
`else
  localparam bit ZICSR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [2:0]  in_sel;
  logic [31:0] in_tag;
  logic        out_ready;

  logic        r32_in_ready, r32_out_valid, r32_err;
  logic [31:0] r32_imm, r32_tag;
  logic        r64_in_ready, r64_out_valid, r64_err;
  logic [63:0] r64_imm;
  logic [31:0] r64_tag;
  logic        ra_in_ready, ra_out_valid, ra_err;
  logic [31:0] ra_imm, ra_tag;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32), .AUTO_SEL(0)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r32_in_ready),
    .in_instr(in_instr), .in_sel(in_sel), .in_tag(in_tag),
    .out_valid(r32_out_valid), .out_ready(out_ready),
    .out_imm(r32_imm), .out_tag(r32_tag), .out_err(r32_err)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32), .AUTO_SEL(0)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r64_in_ready),
    .in_instr(in_instr), .in_sel(in_sel), .in_tag(in_tag),
    .out_valid(r64_out_valid), .out_ready(out_ready),
    .out_imm(r64_imm), .out_tag(r64_tag), .out_err(r64_err)
  );

  imm_gen_pipe #(.XLEN(32), .TAG_W(32), .AUTO_SEL(1)) dut_auto (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ra_in_ready),
    .in_instr(in_instr), .in_sel(in_sel), .in_tag(in_tag),
    .out_valid(ra_out_valid), .out_ready(out_ready),
    .out_imm(ra_imm), .out_tag(ra_tag), .out_err(ra_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Checks the output side of all three instances against one expected transaction.
  task automatic check_out(input string name, input logic valid, input logic [31:0] tag,
                           input logic [31:0] e32, input logic [63:0] e64, input logic eerr,
                           input logic [31:0] ea, input logic eaerr);
    check({name, "/v32"},   64'(r32_out_valid), 64'(valid));
    check({name, "/v64"},   64'(r64_out_valid), 64'(valid));
    check({name, "/vauto"}, 64'(ra_out_valid),  64'(valid));
    if (valid) begin
      check({name, "/tag32"},   64'(r32_tag), 64'(tag));
      check({name, "/tag64"},   64'(r64_tag), 64'(tag));
      check({name, "/tagauto"}, 64'(ra_tag),  64'(tag));
      check({name, "/imm32"},   64'(r32_imm), 64'(e32));
      check({name, "/imm64"},   r64_imm,      e64);
      check({name, "/immauto"}, 64'(ra_imm),  64'(ea));
      check({name, "/err32"},   64'(r32_err), 64'(eerr));
      check({name, "/err64"},   64'(r64_err), 64'(eerr));
      check({name, "/errauto"}, 64'(ra_err),  64'(eaerr));
    end
  endtask

  task automatic check_ready(input string name, input logic exp);
    check({name, "/rdy32"},   64'(r32_in_ready), 64'(exp));
    check({name, "/rdy64"},   64'(r64_in_ready), 64'(exp));
    check({name, "/rdyauto"}, 64'(ra_in_ready),  64'(exp));
  endtask

  // One accepted word with out_ready high; result is checked one cycle after acceptance.
  task automatic xfer(input string name, input logic [31:0] instr, input logic [2:0] sel,
                      input logic [31:0] tag, input logic [31:0] e32, input logic [63:0] e64,
                      input logic eerr, input logic [31:0] ea, input logic eaerr);
    @(negedge clk);
    check_ready(name, 1'b1);
    in_valid  = 1'b1;
    in_instr  = instr;
    in_sel    = sel;
    in_tag    = tag;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check_out(name, 1'b1, tag, e32, e64, eerr, ea, eaerr);
    $display("xfer %-8s instr=%08h sel=%0d tag=%0h imm32=%08h imm64=%016h err=%0b auto=%08h/%0b",
             name, instr, sel, tag, r32_imm, r64_imm, r32_err, ra_imm, ra_err);
  endtask

  function automatic logic [31:0] i_instr(input logic [11:0] imm);
    return {imm, 5'd0, 3'd0, 5'd1, 7'b0010011};
  endfunction

  task automatic offer(input logic [31:0] tag);
    in_valid = 1'b1;
    in_instr = i_instr(tag[11:0]);
    in_sel   = 3'b000;
    in_tag   = tag;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_sel = '0; in_tag = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_ready("reset", 1'b1);
    check({"reset", "/v32"},   64'(r32_out_valid), 64'd0);
    check({"reset", "/v64"},   64'(r64_out_valid), 64'd0);
    check({"reset", "/imm32"}, 64'(r32_imm), 64'd0);
    check({"reset", "/imm64"}, r64_imm, 64'd0);
    check({"reset", "/tag32"}, 64'(r32_tag), 64'd0);
    check({"reset", "/err32"}, 64'(r32_err), 64'd0);
    $display("reset    out_valid=%0b in_ready=%0b imm=%08h tag=%08h", r32_out_valid, r32_in_ready, r32_imm, r32_tag);
    rst = 1'b0;

    xfer("I",     32'hFFF00093, 3'd0, 32'h100, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0, 32'hFFFFFFFF, 1'b0);
    xfer("S",     32'hFE112E23, 3'd1, 32'h104, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0, 32'hFFFFFFFC, 1'b0);
    xfer("B",     32'hFE000EE3, 3'd2, 32'h108, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0, 32'hFFFFFFFC, 1'b0);
    xfer("J",     32'hFF9FF06F, 3'd4, 32'h10C, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 1'b0, 32'hFFFFFFF8, 1'b0);
    xfer("U",     32'h123450B7, 3'd3, 32'h110, 32'h12345000, 64'h0000000012345000, 1'b0, 32'h12345000, 1'b0);
    xfer("U_neg", 32'h800000B7, 3'd3, 32'h114, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0, 32'h80000000, 1'b0);
    xfer("sel7",  32'hFFF00093, 3'd7, 32'h118, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b0);
    xfer("badopc", 32'hFFF0007F, 3'd0, 32'h11C, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0, 32'hFFFFFFFF, 1'b1);
    xfer("Z",     32'h000A8073, 3'd5, 32'h120, ZICSR ? 32'h15 : 32'h0, ZICSR ? 64'h15 : 64'h0,
         !ZICSR, 32'h0, 1'b0);
    xfer("SH",    32'h02500013, 3'd6, 32'h124, ZICSR ? 32'h05 : 32'h25, 64'h25,
         !ZICSR, 32'h25, 1'b0);

    // Backpressure: two words fit (M + K), the third is held off until space frees.
    @(negedge clk);
    out_ready = 1'b0;
    offer(32'd1);
    @(negedge clk);
    check_ready("bp1", 1'b1);
    check_out("bp1", 1'b1, 32'd1, 32'd1, 64'd1, 1'b0, 32'd1, 1'b0);
    offer(32'd2);
    @(negedge clk);
    check_ready("bp2", 1'b0);
    check_out("bp2", 1'b1, 32'd1, 32'd1, 64'd1, 1'b0, 32'd1, 1'b0);
    offer(32'd3);
    @(negedge clk);
    check_ready("bp3", 1'b0);
    check_out("bp3", 1'b1, 32'd1, 32'd1, 64'd1, 1'b0, 32'd1, 1'b0);
    $display("stall    in_ready=%0b out_tag=%0h", r32_in_ready, r32_tag);
    out_ready = 1'b1;
    @(negedge clk);
    check_ready("rel1", 1'b1);
    check_out("rel1", 1'b1, 32'd2, 32'd2, 64'd2, 1'b0, 32'd2, 1'b0);
    $display("release  out_tag=%0h", r32_tag);
    @(negedge clk);
    in_valid = 1'b0;
    check_out("rel2", 1'b1, 32'd3, 32'd3, 64'd3, 1'b0, 32'd3, 1'b0);
    $display("release  out_tag=%0h", r32_tag);
    @(negedge clk);
    check_out("drain", 1'b0, 32'd0, 32'd0, 64'd0, 1'b0, 32'd0, 1'b0);
    check_ready("drain", 1'b1);

    // Reset while FULL discards both held entries.
    out_ready = 1'b0;
    offer(32'hA);
    @(negedge clk);
    offer(32'hB);
    @(negedge clk);
    in_valid = 1'b0;
    check_ready("full", 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    check_out("rstfull", 1'b0, 32'd0, 32'd0, 64'd0, 1'b0, 32'd0, 1'b0);
    check_ready("rstfull", 1'b1);
    check({"rstfull", "/tag32"}, 64'(r32_tag), 64'd0);
    check({"rstfull", "/imm64"}, r64_imm, 64'd0);
    $display("rst_full out_valid=%0b in_ready=%0b tag=%0h", r32_out_valid, r32_in_ready, r32_tag);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_out("nostale", 1'b0, 32'd0, 32'd0, 64'd0, 1'b0, 32'd0, 1'b0);
    end
    xfer("postrst", i_instr(12'h00C), 3'd0, 32'hC, 32'hC, 64'hC, 1'b0, 32'hC, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
